// File: rtl/du_inst_loader.sv
// du_inst_loader
//   Instruction-memory writer for the debug unit. It pops program bytes from
//   a first-word-fall-through UART RX FIFO and packs them MSB-first into
//   NB_REG-bit words. Each completed word gets one write strobe to the
//   pipeline instruction memory.
//   A load ends when one of these happens:
//     - the HALT word is written (success),
//     - MAX_WORDS words have been written (overflow error),
//     - the FIFO stays empty for TIMEOUT_CYC cycles in a row (timeout error).
//   TIMEOUT_CYC = 0 disables the timeout.
//
// Optional feature: define DU_LOADER_CHKSUM_EN to enable the trailing
//   checksum byte. After HALT, one more byte is popped and compared with the
//   XOR of every byte received in this load. A mismatch raises error 11 and
//   o_done is not pulsed.
//
// Ports
//   i_clk         clock
//   i_reset       synchronous, active-high reset
//   i_start       1-cycle pulse that begins a load (ignored unless idle)
//   i_rx_empty    RX FIFO empty
//   i_rx_data     RX FIFO head byte
//   o_rx_rd       FIFO pop; the head byte is consumed in the same cycle
//   o_inst_data   word being written
//   o_inst_addr   word-aligned byte address of the write
//   o_inst_we     1-cycle write strobe
//   o_word_count  number of words written in this load (held after the load)
//   o_busy        load in progress
//   o_done        1-cycle pulse when a load finishes successfully
//   o_error       sticky error flag, cleared by i_start or reset
//   o_err_code    00 none, 01 overflow, 10 timeout, 11 checksum
module du_inst_loader #(
  parameter int unsigned       NB_REG      = 32,
  parameter int unsigned       MAX_WORDS   = 256,
  parameter logic [NB_REG-1:0] HALT_WORD   = 32'hFFFF_FFFF,
  parameter int unsigned       TIMEOUT_CYC = 5_000_000
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_rx_empty,
  input  logic [7:0]                   i_rx_data,
  output logic                         o_rx_rd,
  output logic [NB_REG-1:0]            o_inst_data,
  output logic [31:0]                  o_inst_addr,
  output logic                         o_inst_we,
  output logic [$clog2(MAX_WORDS):0]   o_word_count,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error,
  output logic [1:0]                   o_err_code
);

  localparam int unsigned   CW      = $clog2(MAX_WORDS) + 1;
  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);
  // Last idle count before the timeout fires; the error is raised on the
  // TIMEOUT_CYC-th consecutive empty cycle.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [1:0]    ERR_OVF = 2'b01;
  localparam logic [1:0]    ERR_TMO = 2'b10;
`ifdef DU_LOADER_CHKSUM_EN
  localparam logic [1:0]    ERR_CHK = 2'b11;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET   = 3'd1,
    ST_WRITE = 3'd2,
`ifdef DU_LOADER_CHKSUM_EN
    ST_CHK   = 3'd3,
`endif
    ST_DONE  = 3'd4
  } state_t;

  state_t            state_r, state_nx;
  logic [1:0]        idx_r;
  logic [NB_REG-1:0] word_r;
  logic [NB_REG-1:0] word_nx_s;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_inc_s;
  logic [TW-1:0]     timer_r;
  logic [NB_REG-1:0] data_r;
  logic [31:0]       addr_r;
  logic              we_r, busy_r, done_r, err_r;
  logic [1:0]        code_r;
`ifdef DU_LOADER_CHKSUM_EN
  logic [7:0]        xsum_r;
`endif

  logic       pop_s, shift_s, load_word_s, start_s, cnt_inc_en_s;
  logic       set_err_s, timer_inc_s, to_hit_s;
  logic [1:0] err_code_s;

  assign word_nx_s = {word_r[NB_REG-9:0], i_rx_data};
  assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
  assign to_hit_s  = (TIMEOUT_CYC != 0) && (timer_r == TO_LAST);

  // The pop is the only combinational output: the FWFT byte must be
  // consumed in the same cycle it is observed. Reset suppresses it.
  assign o_rx_rd      = pop_s && !i_reset;
  assign o_inst_data  = data_r;
  assign o_inst_addr  = addr_r;
  assign o_inst_we    = we_r;
  assign o_word_count = cnt_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_error      = err_r;
  assign o_err_code   = code_r;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    state_nx     = state_r;
    pop_s        = 1'b0;
    shift_s      = 1'b0;
    load_word_s  = 1'b0;
    start_s      = 1'b0;
    cnt_inc_en_s = 1'b0;
    set_err_s    = 1'b0;
    timer_inc_s  = 1'b0;
    err_code_s   = 2'b00;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          start_s  = 1'b1;
          state_nx = ST_GET;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GET: begin
        if (!i_rx_empty) begin
          pop_s   = 1'b1;
          shift_s = 1'b1;
          if (idx_r == 2'd3) begin
            load_word_s = 1'b1;
            state_nx    = ST_WRITE;
          end else begin
            state_nx = ST_GET;
          end
        end else if (to_hit_s) begin
          // A partially assembled word is simply dropped.
          set_err_s  = 1'b1;
          err_code_s = ERR_TMO;
          state_nx   = ST_IDLE;
        end else begin
          timer_inc_s = 1'b1;
        end
      end
      ST_WRITE: begin
        cnt_inc_en_s = 1'b1;
        // HALT wins over overflow when it is the last word that fits.
        if (word_r == HALT_WORD) begin
`ifdef DU_LOADER_CHKSUM_EN
          state_nx = ST_CHK;
`else
          state_nx = ST_DONE;
`endif
        end else if (cnt_inc_s == MAX_CNT) begin
          set_err_s  = 1'b1;
          err_code_s = ERR_OVF;
          state_nx   = ST_IDLE;
        end else begin
          state_nx = ST_GET;
        end
      end
`ifdef DU_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (!i_rx_empty) begin
          pop_s = 1'b1;
          if (i_rx_data == xsum_r) begin
            state_nx = ST_DONE;
          end else begin
            set_err_s  = 1'b1;
            err_code_s = ERR_CHK;
            state_nx   = ST_IDLE;
          end
        end else if (to_hit_s) begin
          set_err_s  = 1'b1;
          err_code_s = ERR_TMO;
          state_nx   = ST_IDLE;
        end else begin
          timer_inc_s = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Datapath: byte packing, write port, counters and status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx_r   <= 2'd0;
      word_r  <= {NB_REG{1'b0}};
      cnt_r   <= {CW{1'b0}};
      timer_r <= {TW{1'b0}};
      data_r  <= {NB_REG{1'b0}};
      addr_r  <= 32'd0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      code_r  <= 2'b00;
`ifdef DU_LOADER_CHKSUM_EN
      xsum_r  <= 8'd0;
`endif
    end else begin
      // Strobes are registered one cycle ahead so they line up with state_r.
      we_r   <= load_word_s;
      done_r <= (state_nx == ST_DONE);
      busy_r <= (state_nx != ST_IDLE);
      if (load_word_s) begin
        data_r <= word_nx_s;
        addr_r <= 32'(cnt_r) << 2'd2;
      end
      if (start_s) begin
        idx_r   <= 2'd0;
        word_r  <= {NB_REG{1'b0}};
        cnt_r   <= {CW{1'b0}};
        timer_r <= {TW{1'b0}};
        err_r   <= 1'b0;
        code_r  <= 2'b00;
`ifdef DU_LOADER_CHKSUM_EN
        xsum_r  <= 8'd0;
`endif
      end else begin
        if (cnt_inc_en_s) begin
          cnt_r <= cnt_inc_s;
        end
        if (set_err_s) begin
          err_r  <= 1'b1;
          code_r <= err_code_s;
        end
        if (pop_s) begin
          timer_r <= {TW{1'b0}};
        end else if (timer_inc_s) begin
          timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
        end
        // The byte index wraps 3 -> 0 on its own, ready for the next word.
        if (shift_s) begin
          idx_r  <= idx_r + 2'd1;
          word_r <= word_nx_s;
        end
`ifdef DU_LOADER_CHKSUM_EN
        if (pop_s && (state_r == ST_GET)) begin
          xsum_r <= xsum_r ^ i_rx_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_du_inst_loader.sv
module tb_du_inst_loader;

  localparam int MAXW = 4;
  localparam int TOC  = 100;

  logic        clk = 1'b0;
  logic        i_reset, i_start, i_rx_empty;
  logic [7:0]  i_rx_data;
  logic        o_rx_rd, o_inst_we, o_busy, o_done, o_error;
  logic [31:0] o_inst_data, o_inst_addr;
  logic [2:0]  o_word_count;
  logic [1:0]  o_err_code;

  always #5 clk = ~clk;

  du_inst_loader #(
    .NB_REG(32), .MAX_WORDS(MAXW), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYC(TOC)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_empty(i_rx_empty), .i_rx_data(i_rx_data), .o_rx_rd(o_rx_rd),
    .o_inst_data(o_inst_data), .o_inst_addr(o_inst_addr), .o_inst_we(o_inst_we),
    .o_word_count(o_word_count), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_err_code(o_err_code)
  );

  logic [7:0]  q[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          pop_cyc[$];
  int          done_n, bad_pop_n, cyc;
  bit          gate_en;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: head byte visible while not empty; optional every-other-cycle gating
  task automatic drive_fifo();
    i_rx_empty = (q.size() == 0) || (gate_en && cyc[0]);
    i_rx_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  // One clock: observe at negedge, advance at posedge, update FIFO after it
  task automatic step();
    bit pop_seen;
    @(negedge clk);
    pop_seen = o_rx_rd;
    if (pop_seen) begin
      pop_cyc.push_back(cyc);
      if (i_rx_empty) bad_pop_n++;
    end
    if (o_inst_we) begin
      wr_addr.push_back(o_inst_addr);
      wr_data.push_back(o_inst_data);
      wr_cyc.push_back(cyc);
    end
    if (o_done) done_n++;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_seen && (q.size() != 0)) void'(q.pop_front());
    drive_fifo();
  endtask

  task automatic start_load();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    pop_cyc.delete();
    done_n    = 0;
    bad_pop_n = 0;
    drive_fifo();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int n = 0; (n < budget) && o_busy; n++) step();
    check_val(tag, 32'(o_busy), 32'd0);
  endtask

  task automatic push_prog(input logic [7:0] trailer);
    logic [7:0] prog [8];
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 8; i++) q.push_back(prog[i]);
`ifdef DU_LOADER_CHKSUM_EN
    q.push_back(trailer);
`else
    if (trailer != 8'h00) q.push_back(trailer);
`endif
  endtask

  task automatic check_prog(input string tag);
    check_val({tag, "_nwr"}, 32'(wr_data.size()), 32'd2);
    check_val({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
    check_val({tag, "_d0"}, wr_data[0], 32'h2008_0005);
    check_val({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
    check_val({tag, "_d1"}, wr_data[1], 32'hFFFF_FFFF);
    check_val({tag, "_done"}, 32'(done_n), 32'd1);
    check_val({tag, "_cnt"}, 32'(o_word_count), 32'd2);
    check_val({tag, "_err"}, {29'd0, o_error, o_err_code}, 32'd0);
    check_val({tag, "_badpop"}, 32'(bad_pop_n), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_ctl"}, {24'd0, o_inst_we, o_busy, o_done, o_error, o_err_code, o_rx_rd, 1'b0}, 32'd0);
    check_val({tag, "_data"}, o_inst_data, 32'd0);
    check_val({tag, "_addr"}, o_inst_addr, 32'd0);
    check_val({tag, "_cnt"}, 32'(o_word_count), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    gate_en = 1'b0;
    cyc     = 0;
    drive_fifo();
    repeat (3) step();
    check_reset("rst");
    i_reset = 1'b0;
    step();

    // 1: two-word program ending in HALT; also check write/pop latency
    push_prog(8'h2D);
    start_load();
    wait_idle("s1_idle", 200);
    check_prog("s1");
    check_val("s1_we_lat", 32'(wr_cyc[0]), 32'(pop_cyc[3] + 1));
    check_val("s1_pop_lat", 32'(pop_cyc[4]), 32'(wr_cyc[0] + 1));

    // 2: MAXW non-HALT words -> overflow after the 4th write, no 5th write
    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'(i));
    start_load();
    wait_idle("s2_idle", 200);
    check_val("s2_nwr", 32'(wr_data.size()), 32'd4);
    check_val("s2_a3", wr_addr[3], 32'h0000_000C);
    check_val("s2_d0", wr_data[0], 32'h0001_0203);
    check_val("s2_d3", wr_data[3], 32'h0C0D_0E0F);
    check_val("s2_err", {29'd0, o_error, o_err_code}, 32'h5);
    check_val("s2_done", 32'(done_n), 32'd0);
    check_val("s2_cnt", 32'(o_word_count), 32'd4);
    check_val("s2_left", 32'(q.size()), 32'd4);

    // 3: two bytes then a stall -> timeout on the 100th empty cycle
    q.delete();
    q.push_back(8'hAA);
    q.push_back(8'hBB);
    start_load();
    step();
    step();
    repeat (TOC - 1) step();
    check_val("s3_pre_err", 32'(o_error), 32'd0);
    check_val("s3_pre_busy", 32'(o_busy), 32'd1);
    step();
    check_val("s3_err", {29'd0, o_error, o_err_code}, 32'h6);
    check_val("s3_busy", 32'(o_busy), 32'd0);
    check_val("s3_nwr", 32'(wr_data.size()), 32'd0);

    // 4: FIFO empty toggling every other cycle
    q.delete();
    gate_en = 1'b1;
    push_prog(8'h2D);
    start_load();
    wait_idle("s4_idle", 400);
    check_prog("s4");
    gate_en = 1'b0;

    // 5: reset after byte 2, then a fresh load from address 0
    q.delete();
    push_prog(8'h2D);
    start_load();
    step();
    step();
    i_reset = 1'b1;
    step();
    check_reset("s5_rst");
    i_reset = 1'b0;
    q.delete();
    push_prog(8'h2D);
    start_load();
    wait_idle("s5_idle", 200);
    check_prog("s5");

`ifdef DU_LOADER_CHKSUM_EN
    // 6: checksum trailer mismatch
    q.delete();
    push_prog(8'h00);
    start_load();
    wait_idle("s6_idle", 200);
    check_val("s6_nwr", 32'(wr_data.size()), 32'd2);
    check_val("s6_err", {29'd0, o_error, o_err_code}, 32'h7);
    check_val("s6_done", 32'(done_n), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
